// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared FSM states, ALU opcodes and widths for the ALU arbiter
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_SLTU = 3'b111
  } alu_op_t;

  // With both requesters pending, the pointer names the one that wins.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic prio);
    if (v0 && v1) begin
      return prio;
    end
    return v1 && !v0;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU with an operand-equality Zero flag
import alu_pkg::*;

module alu (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_NAND: result = ~(a & b);
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

  assign zero = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one ALU
import alu_pkg::*;

module alu_arbiter (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_id
);

  state_t            state;
  state_t            next_state;
  logic              prio;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  alu_op_t           op_q;
  logic              id_q;

  logic              grant_valid;
  logic              grant_id;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_valid = req0_valid || req1_valid;
        grant_id    = pick_grant(req0_valid, req1_valid, prio);
        if (grant_valid) begin
          next_state = ST_EXEC;
        end
        // Ready is masked during reset so no requester sees a phantom accept.
        req0_ready = grant_valid && !grant_id && !reset;
        req1_ready = grant_valid && grant_id && !reset;
      end
      ST_EXEC: begin
        next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            a_q  <= grant_id ? req1_a : req0_a;
            b_q  <= grant_id ? req1_b : req0_b;
            op_q <= alu_op_t'(grant_id ? req1_op : req0_op);
            id_q <= grant_id;
            prio <= !grant_id;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_id;

  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 0;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return ~(a & b);
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Transaction model: one op in flight, visible two edges after accept, retired on rsp_ready.
  bit          m_busy = 0, m_vis = 0, m_pref = 0;
  logic [31:0] m_res = 0, p_res = 0;
  bit          m_zero = 0, m_id = 0, p_zero = 0, p_id = 0;
  bit          exp_r0, exp_r1;

  always @(negedge clk) begin
    if (mon_on) begin
      exp_r0 = !reset && !m_busy && req0_valid && (!req1_valid || !m_pref);
      exp_r1 = !reset && !m_busy && req1_valid && (!req0_valid || m_pref);
      check("m_req0_ready", {31'd0, req0_ready}, {31'd0, exp_r0});
      check("m_req1_ready", {31'd0, req1_ready}, {31'd0, exp_r1});
      check("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_vis});
      check("m_rsp_result", rsp_result, m_res);
      check("m_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
      check("m_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      if (reset) begin
        m_busy = 0; m_vis = 0; m_pref = 0;
        m_res = 0; m_zero = 0; m_id = 0;
      end else if (!m_busy) begin
        if (exp_r0 || exp_r1) begin
          p_id   = exp_r1;
          p_res  = exp_r1 ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
          p_zero = exp_r1 ? (req1_a == req1_b) : (req0_a == req0_b);
          m_busy = 1;
          m_pref = !exp_r1;
        end
      end else if (!m_vis) begin
        m_res = p_res; m_zero = p_zero; m_id = p_id; m_vis = 1;
      end else if (rsp_ready) begin
        m_vis = 0; m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    bit ok;
    ok = 0;
    req0_valid = !id; req1_valid = id;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_a = a; req0_b = b; req0_op = op; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    check("issue_ready_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic await_rsp();
    bit ok;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    check("rsp_timeout", {31'd0, ok}, 32'd1);
  endtask

  logic [31:0] sweep_exp [8];
  int          seen_cyc [$];
  bit          seen_id [$];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sweep_exp = '{32'h2, 32'h4, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'h1};
    reset = 1; rsp_ready = 1;
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 3'd0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;

    // Reset state, ready masked while reset is high
    tick();
    mon_on = 1;
    @(negedge clk);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);

    // Single request: accept at cycle 1, response at cycle 3
    tick(); reset = 0;
    @(negedge clk);
    check("single_ready_c1", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 0;
    @(negedge clk);
    check("single_valid_c2", {31'd0, rsp_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("single_valid_c3", {31'd0, rsp_valid}, 32'd1);
    check("single_result", rsp_result, 32'd12);
    check("single_zero", {31'd0, rsp_zero}, 32'd0);
    check("single_id", {31'd0, rsp_id}, 32'd0);
    tick();

    // Opcode sweep
    for (int op = 0; op < 8; op++) begin
      issue(0, 32'h3, 32'hFFFF_FFFF, op[2:0]);
      await_rsp();
      check($sformatf("sweep_op%0d", op), rsp_result, sweep_exp[op]);
      tick();
    end

    // Backpressure with req0 waiting behind it
    rsp_ready = 0;
    issue(1, 32'd9, 32'd9, 3'd1);
    req0_valid = 1; req0_a = 32'd40; req0_b = 32'd2; req0_op = 3'd1;
    await_rsp();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_result", rsp_result, 32'd0);
      check("bp_zero", {31'd0, rsp_zero}, 32'd1);
      check("bp_id", {31'd0, rsp_id}, 32'd1);
      check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
    end
    tick(); rsp_ready = 1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    @(negedge clk);
    check("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_idle_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 0;
    await_rsp();
    check("bp_followup_result", rsp_result, 32'd38);
    tick();

    // Reset during HOLD discards the response and re-arms the pointer
    rsp_ready = 0;
    issue(1, 32'd1, 32'd2, 3'd0);
    await_rsp();
    tick();
    reset = 1; req0_valid = 1; req1_valid = 1;
    req0_a = 32'd20; req0_b = 32'd22; req0_op = 3'd0;
    @(negedge clk);
    check("hold_rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("hold_rst_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); reset = 0; rsp_ready = 1;
    @(negedge clk);
    check("hold_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("hold_rst_result", rsp_result, 32'd0);
    check("hold_rst_grant0", {31'd0, req0_ready}, 32'd1);
    check("hold_rst_grant1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 0; req1_valid = 0;
    await_rsp();
    check("hold_rst_next_id", {31'd0, rsp_id}, 32'd0);
    check("hold_rst_next_res", rsp_result, 32'd42);
    tick();

    // Operand change after acceptance has no effect
    issue(0, 32'd100, 32'd23, 3'd0);
    req0_a = 32'd5000;
    await_rsp();
    check("late_change_result", rsp_result, 32'd123);
    tick();

    // Contention from reset: alternating grants every 3 cycles
    reset = 1;
    req0_valid = 1; req0_a = 32'd7; req0_b = 32'd1; req0_op = 3'd1;
    req1_valid = 1; req1_a = 32'd7; req1_b = 32'd1; req1_op = 3'd0;
    tick(); reset = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin seen_cyc.push_back(c); seen_id.push_back(rsp_id); end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    check("cont_count", seen_cyc.size(), 32'd4);
    for (int k = 0; k < seen_cyc.size() && k < 4; k++) begin
      check("cont_cycle", seen_cyc[k], 3 * (k + 1));
      check("cont_id", {31'd0, seen_id[k]}, k % 2);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_op    = 3'($urandom_range(0, 7));
      req1_op    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        req0_a = $urandom_range(0, 3); req0_b = $urandom_range(0, 3);
        req1_a = $urandom_range(0, 3); req1_b = $urandom_range(0, 3);
      end else begin
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
      end
      tick();
    end

    reset = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and opcode width at 3 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 ALU selection code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions, widths and meanings, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_result  output  32  registered ALU result.
REQ-012 rsp_zero  output  1  registered ALU Zero flag (A equals B) for the operands.
REQ-013 rsp_id  output  1  index of the requester that issued the result.

Function
REQ-014 The block SHALL share one ALU instance between two requesters using a three-state FSM: IDLE, EXEC, HOLD.
REQ-015 IDLE: no valid -> stay IDLE; one valid -> grant it; both valid -> grant the requester not granted most recently.
REQ-016 reqN_ready SHALL be 1 only in IDLE, only for the granted requester, combinationally from state, valids and priority pointer.
REQ-017 On grant, operands, opcode and requester id SHALL be latched into internal registers and the FSM SHALL move to EXEC.
REQ-018 EXEC: ALU evaluates latched operands; result, Zero and id SHALL be registered into rsp_* outputs, rsp_valid set to 1, FSM to HOLD.
REQ-019 Latency: accept at cycle N -> rsp_valid high at cycle N+2; maximum throughput one operation per 3 cycles with rsp_ready held high.
REQ-020 HOLD: rsp_valid, rsp_result, rsp_zero, rsp_id SHALL stay stable until rsp_ready=1; on that edge rsp_valid clears and FSM returns to IDLE.
REQ-021 The priority pointer SHALL update on grant to point at the other requester.
REQ-022 Requester inputs outside the accept cycle SHALL be ignored; changing operands after acceptance SHALL not affect the result.
REQ-023 Requesters SHALL hold valid and payload until ready; the block SHALL not buffer unaccepted requests.
REQ-024 ALU op codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 nand, 111 unsigned set-less-than (1/0); add/sub wrap modulo 2^32, no carry output.
REQ-025 A valid deasserted while not granted SHALL simply not be served; no error signalling.

Reset
REQ-026 reset SHALL force FSM to IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, operand/opcode registers=0, priority pointer to requester 0.
REQ-027 reset asserted in EXEC or HOLD SHALL discard the in-flight operation; no response is produced for it.
REQ-028 reqN_ready SHALL be 0 during any cycle with reset high.

Structure
REQ-029 FSM state encodings and ALU opcode constants SHALL live in a shared package (alu_pkg).
REQ-030 The existing 32-bit alu module SHALL be instantiated once as the only sub-module; no second ALU copy.

Verification
REQ-031 Single request: req0 add A=5,B=7 at cycle 1 -> req0_ready=1 cycle 1, rsp_valid=1 cycle 3, rsp_result=12, rsp_zero=0, rsp_id=0.
REQ-032 Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; results appear every 3 cycles with alternating rsp_id.
REQ-033 Backpressure: req1 sub A=9,B=9, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result=0, rsp_zero=1 held stable; req0_ready=0 throughout; IDLE resumes after rsp_ready=1.
REQ-034 Opcode sweep: A=32'h0000_0003, B=32'hFFFF_FFFF, all 8 ops -> 2, 4, 3, FFFF_FFFF, FFFF_FFFC, 0, FFFF_FFFC, 1.
REQ-035 Reset in HOLD: assert reset one cycle during HOLD -> rsp_valid=0 next cycle, no stale response after release, next grant goes to req0 when both valid.
REQ-036 Operand change after accept: req0_a changed 1 cycle after acceptance -> rsp_result reflects originally latched values.
